// File: rtl/wb_bus_decoder.sv
// Wishbone classic 1-master / N-slave router: registered decode, unmapped-address error responder.
// Optional bus timeout when WB_TIMEOUT_EN is defined.
module wb_bus_decoder #(
   parameter int N_SLAVES       = 5,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE =
      {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = {N_SLAVES{32'hF000_0000}},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [AW-1:0]            m_adr_i,
   input  logic [DW-1:0]            m_dat_i,
   input  logic [DW/8-1:0]          m_sel_i,
   input  logic                     m_we_i,
   input  logic                     m_cyc_i,
   input  logic                     m_stb_i,
   output logic [DW-1:0]            m_dat_o,
   output logic                     m_ack_o,
   output logic                     m_err_o,
   output logic [N_SLAVES*AW-1:0]   s_adr_o,
   output logic [N_SLAVES*DW-1:0]   s_dat_o,
   output logic [N_SLAVES*DW/8-1:0] s_sel_o,
   output logic [N_SLAVES-1:0]      s_we_o,
   output logic [N_SLAVES-1:0]      s_cyc_o,
   output logic [N_SLAVES-1:0]      s_stb_o,
   input  logic [N_SLAVES*DW-1:0]   s_dat_i,
   input  logic [N_SLAVES-1:0]      s_ack_i,
   input  logic [N_SLAVES-1:0]      s_err_i,
   output logic                     busy_o,
   output logic [AW-1:0]            last_err_adr_o
);
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DERR} state_t;

   state_t              r_state, w_next;
   logic [N_SLAVES-1:0] r_sel, w_hit;
   logic [AW-1:0]       r_last_err;
   logic [DW-1:0]       w_sdat;
   logic                w_req, w_sack, w_serr, w_tout;

   assign w_req  = m_cyc_i & m_stb_i;
   assign w_sack = |(s_ack_i & r_sel);
   assign w_serr = |(s_err_i & r_sel);

   // Scan high-to-low so the lowest matching slot overwrites the rest.
   always_comb begin
      w_hit = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((m_adr_i & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
            w_hit    = '0;
            w_hit[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_sdat = '0;
      for (int i = 0; i < N_SLAVES; i++)
         if (r_sel[i]) w_sdat = w_sdat | s_dat_i[i*DW +: DW];
   end

`ifdef WB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;

   // A slave response on the last allowed cycle takes priority over the timeout.
   assign w_tout = (r_state == S_ACTIVE) && m_cyc_i && !w_sack && !w_serr &&
                   (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                       r_cnt <= '0;
      else if (r_state != S_ACTIVE)                       r_cnt <= '0;
      else if (!w_sack && !w_serr)                        r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_tout = 1'b0;
`endif

   always_comb begin
      w_next  = r_state;
      s_cyc_o = '0;
      s_stb_o = '0;
      m_ack_o = 1'b0;
      m_err_o = 1'b0;
      m_dat_o = '0;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_next = (|w_hit) ? S_ACTIVE : S_DERR;
         end
         S_ACTIVE: begin
            if (!m_cyc_i) begin
               w_next = S_IDLE;
            end else begin
               if (!w_tout && m_stb_i) begin
                  s_cyc_o = r_sel;
                  s_stb_o = r_sel;
               end
               m_dat_o = w_sdat;
               m_err_o = w_serr | w_tout;
               m_ack_o = w_sack & ~w_serr;
               if (w_sack || w_serr || w_tout) w_next = S_IDLE;
            end
         end
         S_DERR: begin
            w_next  = S_IDLE;
            m_err_o = m_cyc_i;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_last_err <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_req)             r_sel <= w_hit;
         else if (r_state != S_IDLE && w_next == S_IDLE) r_sel <= '0;
         if ((r_state == S_DERR && m_cyc_i) || w_tout) r_last_err <= m_adr_i;
      end
   end

   assign s_adr_o        = {N_SLAVES{m_adr_i}};
   assign s_dat_o        = {N_SLAVES{m_dat_i}};
   assign s_sel_o        = {N_SLAVES{m_sel_i}};
   assign s_we_o         = {N_SLAVES{m_we_i}};
   assign busy_o         = (r_state != S_IDLE);
   assign last_err_adr_o = r_last_err;
endmodule

// File: tb/tb_wb_bus_decoder.sv
// Bench for wb_bus_decoder: vector table through a scoreboard plus abort, timeout and reset sequences.
module tb_wb_bus_decoder;
   localparam int N = 5, AW = 32, DW = 32, SW = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [AW-1:0]   m_adr;
   logic [DW-1:0]   m_dat;
   logic [SW-1:0]   m_sel;
   logic            m_we, m_cyc, m_stb;
   logic [DW-1:0]   m_dat_o,  o_m_dat_o;
   logic            m_ack_o,  m_err_o, o_m_ack_o, o_m_err_o;
   logic [N*AW-1:0] s_adr_o,  o_s_adr_o;
   logic [N*DW-1:0] s_dat_o,  o_s_dat_o, s_dat_i;
   logic [N*SW-1:0] s_sel_o,  o_s_sel_o;
   logic [N-1:0]    s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [N-1:0]    o_s_we_o, o_s_cyc_o, o_s_stb_o, o_s_ack_i, o_s_err_i;
   logic            busy_o, o_busy_o;
   logic [AW-1:0]   last_err_adr_o, o_last_err_adr_o;
   logic [N-1:0]    ack_en, err_en;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic        serr;
      logic        exp_err;
      logic [4:0]  exp_stb;
      logic [31:0] exp_rdat;
   } rec_t;

   rec_t tbl[8];
   rec_t sb_q[$];

   always #5 clk = ~clk;

   // Zero-wait slave models; slot 1 returns the reference read value.
   always_comb begin
      s_dat_i = '0;
      for (int k = 0; k < N; k++)
         s_dat_i[k*DW +: DW] = (k == 1) ? 32'hCAFE_F00D : (32'h5A00_0000 + 32'(k));
   end
   assign s_ack_i   = s_stb_o & ack_en;
   assign s_err_i   = s_stb_o & err_en;
   assign o_s_ack_i = o_s_stb_o & ack_en;
   assign o_s_err_i = o_s_stb_o & err_en;

   wb_bus_decoder #(.N_SLAVES(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .busy_o(busy_o), .last_err_adr_o(last_err_adr_o));

   // Slot 0 is a catch-all overlapping every other slot.
   wb_bus_decoder #(.N_SLAVES(N), .AW(AW), .DW(DW),
      .SLAVE_MASK({{4{32'hF000_0000}}, 32'h0000_0000})) u_ovl (
      .clk(clk), .reset_n(reset_n),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(o_m_dat_o), .m_ack_o(o_m_ack_o), .m_err_o(o_m_err_o),
      .s_adr_o(o_s_adr_o), .s_dat_o(o_s_dat_o), .s_sel_o(o_s_sel_o), .s_we_o(o_s_we_o),
      .s_cyc_o(o_s_cyc_o), .s_stb_o(o_s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(o_s_ack_i), .s_err_i(o_s_err_i),
      .busy_o(o_busy_o), .last_err_adr_o(o_last_err_adr_o));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] adr, input logic we, input logic [31:0] d,
                        input logic [3:0] sel);
      m_adr = adr; m_we = we; m_dat = d; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
   endtask

   task automatic release_bus();
      m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
   endtask

   task automatic xfer(input rec_t r);
      rec_t e;
      int   n;
      logic [31:0] prev_err;
      prev_err = last_err_adr_o;
      sb_q.push_back(r);
      err_en = r.serr ? r.exp_stb : '0;
      @(posedge clk); #1;
      drive(r.adr, r.we, r.wdat, r.sel);
      @(negedge clk);
      chk("decode_cycle_no_stb", s_stb_o, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_ack_o || m_err_o) && n < 16);
      e = sb_q.pop_front();
      chk("latency", n, 1);
      chk("m_err_o", m_err_o, e.exp_err);
      chk("m_ack_o", m_ack_o, !e.exp_err);
      chk("s_stb_o", s_stb_o, e.exp_stb);
      chk("m_dat_o", m_dat_o, e.exp_rdat);
      chk("ovl_stb", o_s_stb_o, 5'b00001);
      if (e.we) begin
         chk("bcast_dat4", s_dat_o[4*DW +: DW], e.wdat);
         chk("bcast_sel4", s_sel_o[4*SW +: SW], e.sel);
         chk("bcast_we",   s_we_o, 5'b11111);
         chk("bcast_adr0", s_adr_o[0 +: AW], e.adr);
      end
      @(posedge clk); #1;
      release_bus();
      err_en = '0;
      @(negedge clk);
      chk("busy_after", busy_o, 0);
      chk("last_err_adr", last_err_adr_o, (e.exp_err && !e.serr) ? e.adr : prev_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs_seen;
      tbl[0] = '{32'h1000_0004, 1'b0, 32'h0,         4'hF, 1'b0, 1'b0, 5'b00010, 32'hCAFE_F00D};
      tbl[1] = '{32'h4000_0010, 1'b1, 32'h0000_00A5, 4'h1, 1'b0, 1'b0, 5'b10000, 32'h5A00_0004};
      tbl[2] = '{32'h7000_0000, 1'b0, 32'h0,         4'hF, 1'b0, 1'b1, 5'b00000, 32'h0};
      tbl[3] = '{32'h2000_0000, 1'b0, 32'h0,         4'hF, 1'b0, 1'b0, 5'b00100, 32'h5A00_0002};
      tbl[4] = '{32'h0000_0000, 1'b0, 32'h0,         4'hF, 1'b0, 1'b0, 5'b00001, 32'h5A00_0000};
      tbl[5] = '{32'h3FFF_FFFC, 1'b1, 32'h1234_5678, 4'hC, 1'b0, 1'b0, 5'b01000, 32'h5A00_0003};
      tbl[6] = '{32'hF000_0000, 1'b0, 32'h0,         4'hF, 1'b0, 1'b1, 5'b00000, 32'h0};
      tbl[7] = '{32'h2000_0008, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 5'b00100, 32'h5A00_0002};

      reset_n = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
      m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
      ack_en = '1; err_en = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_ack",  m_ack_o, 0);
      chk("rst_err",  m_err_o, 0);
      chk("rst_dat",  m_dat_o, 0);
      chk("rst_cyc",  s_cyc_o, 0);
      chk("rst_stb",  s_stb_o, 0);
      chk("rst_last", last_err_adr_o, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) xfer(tbl[i]);

      // Master abort while slot 0 stalls.
      ack_en = 5'b11110;
      @(posedge clk); #1;
      drive(32'h0000_0100, 1'b0, 32'h0, 4'hF);
      repeat (3) @(negedge clk);
      chk("stall_stb", s_stb_o, 5'b00001);
      chk("stall_ack", m_ack_o, 0);
      @(posedge clk); #1;
      release_bus();
      @(negedge clk);
      chk("abort_cyc",  s_cyc_o, 0);
      chk("abort_ack",  m_ack_o, 0);
      chk("abort_err",  m_err_o, 0);
      chk("abort_busy", busy_o, 1);
      @(negedge clk);
      chk("abort_idle", busy_o, 0);
      chk("abort_last", last_err_adr_o, 32'hF000_0000);

      // Slot 3 never responds.
      ack_en = 5'b10111;
      @(posedge clk); #1;
      drive(32'h3000_0000, 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      errs_seen = 0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (m_err_o || m_ack_o) errs_seen++;
      end
      chk("no_early_term", errs_seen, 0);
`ifdef WB_TIMEOUT_EN
      @(negedge clk);
      chk("tout_err", m_err_o, 1);
      chk("tout_ack", m_ack_o, 0);
      chk("tout_cyc", s_cyc_o, 0);
      @(posedge clk); #1;
      release_bus();
      @(negedge clk);
      chk("tout_idle", busy_o, 0);
      chk("tout_last", last_err_adr_o, 32'h3000_0000);
`else
      for (int c = 8; c <= 20; c++) begin
         @(negedge clk);
         if (m_err_o || m_ack_o) errs_seen++;
      end
      chk("no_timeout", errs_seen, 0);
      chk("wait_cyc",   s_cyc_o, 5'b01000);
      chk("wait_busy",  busy_o, 1);
      @(posedge clk); #1;
      release_bus();
      @(negedge clk);
      @(negedge clk);
      chk("wait_abort_idle", busy_o, 0);
      chk("wait_last", last_err_adr_o, 32'hF000_0000);
`endif

      // Asynchronous reset in the middle of a stalled transfer.
      ack_en = 5'b11110;
      @(posedge clk); #1;
      drive(32'h0000_0200, 1'b0, 32'h0, 4'hF);
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", busy_o, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_cyc",  s_cyc_o, 0);
      chk("mid_rst_stb",  s_stb_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_ack",  m_ack_o, 0);
      chk("mid_rst_err",  m_err_o, 0);
      chk("mid_rst_dat",  m_dat_o, 0);
      chk("mid_rst_last", last_err_adr_o, 0);
      release_bus();
      @(posedge clk); #1;
      reset_n = 1'b1;
      ack_en = '1;
      xfer(tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
